// File: rtl/mode_counter.sv
// mode_counter: falling-edge up/down counter with saturate or wrap modes.
// Optional prescaler is enabled by defining MODE_COUNTER_PRESCALE_EN.
module mode_counter #(
   parameter int WIDTH = 5
`ifdef MODE_COUNTER_PRESCALE_EN
   , parameter int PRESCALE = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             wrap,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] value,
   output logic             done,
   output logic             tc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] value_n;
   logic             tc_n;
   logic             tick;
   logic             lt;
   logic             gt;
   logic             eq;
   logic             nz;

`ifdef MODE_COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] presc;
   logic [PW-1:0] presc_n;

   // Prescaler: advances only on enabled edges outside DONE, cleared by load.
   always_comb begin
      presc_n = presc;
      tick    = 1'b0;
      if (load) begin
         presc_n = '0;
      end else if (en && (state != DONE)) begin
         if (presc == PMAX) begin
            presc_n = '0;
            tick    = 1'b1;
         end else begin
            presc_n = presc + 1'b1;
         end
      end
   end

   // Prescaler register.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else begin
         presc <= presc_n;
      end
   end
`else
   assign tick = 1'b1;
`endif

   assign lt = (value < limit);
   assign gt = (value > limit);
   assign eq = (value == limit);
   assign nz = (value != '0);

   // Next state, next count and wrap pulse; load overrides any step.
   always_comb begin
      state_n = state;
      value_n = value;
      tc_n    = 1'b0;
      if (load) begin
         value_n = (load_val > limit) ? limit : load_val;
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE, RUN: begin
               if (!en) begin
                  state_n = IDLE;
               end else begin
                  state_n = RUN;
                  if (tick) begin
                     unique case (1'b1)
                        (up && lt): begin
                           value_n = value + 1'b1;
                        end
                        (up && gt): begin
                           value_n = limit;
                           if (!wrap) state_n = DONE;
                        end
                        (up && eq): begin
                           if (wrap) begin
                              value_n = '0;
                              tc_n    = 1'b1;
                           end else begin
                              state_n = DONE;
                           end
                        end
                        (!up && nz): begin
                           value_n = value - 1'b1;
                        end
                        (!up && !nz): begin
                           if (wrap) begin
                              value_n = limit;
                              tc_n    = 1'b1;
                           end else begin
                              state_n = DONE;
                           end
                        end
                        default: begin
                           value_n = value;
                        end
                     endcase
                  end
               end
            end
            DONE: begin
               state_n = DONE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // State, count and pulse registers, all on the falling edge.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         value <= '0;
         tc    <= 1'b0;
      end else begin
         state <= state_n;
         value <= value_n;
         tc    <= tc_n;
      end
   end

   assign done = (state == DONE);

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 5, bit width of the count value.
REQ-002 SHALL provide parameter PRESCALE, default 4, enabled edges per count step (used only with MODE_COUNTER_PRESCALE_EN).
REQ-003 Port: clk  input  1  clock; all state updates on the falling edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: en  input  1  count enable.
REQ-006 Port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 Port: wrap  input  1  mode; 1 = wrap-around, 0 = saturate and stop.
REQ-008 Port: load  input  1  synchronous load strobe.
REQ-009 Port: load_val  input  WIDTH  value to load.
REQ-010 Port: limit  input  WIDTH  upper count bound; 0 is the lower bound.
REQ-011 Port: value  output  WIDTH  current count, registered.
REQ-012 Port: done  output  1  high while in DONE state.
REQ-013 Port: tc  output  1  one-cycle pulse on each wrap-around event.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE, all transitions on negedge clk.
REQ-015 IDLE->RUN when en=1; RUN->IDLE when en=0; DONE exits only on load (->IDLE) or rst.
REQ-016 Priority per edge: rst > load > count step > hold.
REQ-017 Load SHALL set value = min(load_val, limit), clear done, restart the prescaler and leave the state in IDLE; count resumes on the following enabled edge.
REQ-018 In RUN with up=1: value<limit -> value+1; value>=limit -> terminal.
REQ-019 In RUN with up=0: value>0 -> value-1; value==0 -> terminal.
REQ-020 Terminal with wrap=0: value is held (limit when counting up, 0 when counting down) and the state goes to DONE; no tc.
REQ-021 Terminal with wrap=1: up loads 0, down loads limit, tc=1 for exactly that cycle, state stays RUN.
REQ-022 If limit is lowered below value while in RUN, the next up step SHALL set value=limit and treat it as terminal; a down step decrements normally.
REQ-023 limit==0 SHALL be legal: every step is terminal; with wrap=1, tc pulses on every step and value stays 0.
REQ-024 Changes to up or wrap SHALL take effect at the next step; DONE is not left by a mode change.
REQ-025 Arithmetic is WIDTH-bit unsigned; no intermediate overflow reaches value.
REQ-026 tc SHALL be low on every edge without a wrap event.

Reset
REQ-027 rst=1 SHALL immediately force value=0, done=0, tc=0, state=IDLE and prescaler=0, independent of clk.
REQ-028 Release of rst mid-count SHALL resume from value 0 on the first falling edge with en=1.

Configuration
REQ-029 With macro MODE_COUNTER_PRESCALE_EN defined, a count step SHALL occur only on every PRESCALE-th edge with en=1 in RUN. The prescaler holds while en=0 and clears on load or rst.
REQ-030 Without MODE_COUNTER_PRESCALE_EN, every edge with en=1 in RUN SHALL be a count step; the PRESCALE parameter and prescaler logic are absent.

Verification
REQ-031 rst pulse, then en=1, up=1, wrap=0, limit=31 for 40 edges -> value 1..31, then done=1 and value holds at 31.
REQ-032 load_val=3, limit=5, up=1, wrap=1 -> value 4,5,0 with tc=1 only on the edge where value becomes 0, then 1,2.
REQ-033 value=2, up=0, wrap=0 -> 1,0, then done=1 with value 0; load load_val=7 with limit=5 -> value=5, done=0.
REQ-034 value=20 in RUN, limit changed to 10, up=1 -> next edge value=10, done=1 (wrap=0); with wrap=1 -> value=10, then 0 with tc pulse.
REQ-035 rst asserted between edges at value=9 -> value=0 without a clk edge; load and en asserted on the same edge -> load wins.
REQ-036 MODE_COUNTER_PRESCALE_EN, PRESCALE=4, en=1, up=1 for 12 edges -> value increments exactly 3 times; en=0 for 2 edges mid-sequence does not advance the prescaler.
